// File: rtl/sprite_position_ctrl.sv
// sprite_position_ctrl
//
// Upstream control stage for the HDMI sprite pipeline. A raw push-button is
// synchronized and debounced; each debounced press captures a pseudo-random
// sprite position and pop flag from a free-running 16-bit LFSR into a pending
// slot. The pending value is committed to the outputs only when a frame-start
// pulse arrives, so the sprite never moves mid-frame.
//
// Ports:
//   clk_in        pixel clock, sole clock
//   rst_in        asynchronous, active-high reset
//   btn_in        raw asynchronous push-button
//   new_frame_in  one-cycle frame-start pulse from the video timing generator
//   x_out         sprite top-left x, 0..(H_ACTIVE-SPRITE_W)
//   y_out         sprite top-left y, 0..(V_ACTIVE-SPRITE_H)
//   pop_out       sprite pop/variant flag
//   update_out    one-cycle pulse in the cycle the outputs take a new value

module sprite_position_ctrl #(
  parameter int DEBOUNCE_CYCLES = 742500,
  parameter int H_ACTIVE        = 1280,
  parameter int V_ACTIVE        = 720,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_in,
  input  logic        new_frame_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        update_out
);

  localparam int XMAX  = H_ACTIVE - SPRITE_W;
  localparam int YMAX  = V_ACTIVE - SPRITE_H;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]      XMAX_V    = 11'(XMAX);
  localparam logic [8:0]       YMAX_V    = 9'(YMAX);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  // IDLE: nothing waiting for a frame boundary; ARMED: a capture is pending
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_state_q, db_state_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [10:0]      px_q, px_d;
  logic [8:0]       py_q, py_d;
  logic             pp_q, pp_d;
  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             pop_q, pop_d;
  logic             update_q, update_d;

  logic             btn_sync;
  logic             press;
  logic             pending;
  logic             commit;
  logic [10:0]      cx;
  logic [8:0]       cy;
  logic [10:0]      px_cap;
  logic [8:0]       py_cap;

  // Synchronizer, debouncer and LFSR next-state logic
  always_comb begin
    sync1_d    = btn_in;
    sync2_d    = sync1_q;
    btn_sync   = sync2_q;

    db_state_d = db_state_q;
    db_prev_d  = db_state_q;
    cnt_d      = cnt_q;
    // The counter measures how long btn_sync has disagreed with the accepted
    // level; any return to agreement discards the partial count.
    if (btn_sync == db_state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_state_d = ~db_state_q;
      cnt_d      = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Only the 0->1 debounced edge counts as a press; release is silent
    press  = db_state_q & ~db_prev_q;

    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Fold the raw LFSR fields into the legal position range. The legal
  // configuration guarantees a single subtraction is enough.
  always_comb begin
    cx     = lfsr_q[10:0];
    cy     = lfsr_q[15:7];
    px_cap = (cx > XMAX_V) ? (cx - XMAX_V - 11'd1) : cx;
    py_cap = (cy > YMAX_V) ? (cy - YMAX_V - 9'd1) : cy;
  end

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a press always (re)arms, a frame pulse disarms unless a
  // press lands in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (press) begin
          state_d = ARMED;
        end else if (new_frame_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: commit the old pending value and capture a new one
  // independently, so a simultaneous press and frame pulse does both
  always_comb begin
    pending  = (state_q == ARMED);
    commit   = new_frame_in & pending;

    x_d      = x_q;
    y_d      = y_q;
    pop_d    = pop_q;
    update_d = commit;
    if (commit) begin
      x_d   = px_q;
      y_d   = {1'b0, py_q};
      pop_d = pp_q;
    end

    px_d = px_q;
    py_d = py_q;
    pp_d = pp_q;
    if (press) begin
      px_d = px_cap;
      py_d = py_cap;
      pp_d = lfsr_q[0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_state_q <= 1'b0;
      db_prev_q  <= 1'b0;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      px_q       <= '0;
      py_q       <= '0;
      pp_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pop_q      <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_state_q <= db_state_d;
      db_prev_q  <= db_prev_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pp_q       <= pp_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pop_q      <= pop_d;
      update_q   <= update_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign pop_out    = pop_q;
  assign update_out = update_q;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// tb_sprite_position_ctrl
//
// Self-checking bench for sprite_position_ctrl with a short debounce window.
// A behavioural model (streak-counting debouncer, mask-parity LFSR, modulo
// position folding) predicts every output each cycle.
//
// Ports of the DUT are all driven/observed from this module; no ports here.

module tb_sprite_position_ctrl;

  localparam int D        = 4;
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int SPRITE_W = 256;
  localparam int SPRITE_H = 256;
  localparam int XMAX     = H_ACTIVE - SPRITE_W;
  localparam int YMAX     = V_ACTIVE - SPRITE_H;

  logic        clk_in;
  logic        rst_in;
  logic        btn_in;
  logic        new_frame_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        pop_out;
  logic        update_out;

  int tests = 0;
  int fails = 0;

  // Reference model state (values the DUT should hold after the last edge)
  logic        m_s1, m_s2, m_db, m_dbprev;
  int          m_run;
  logic [15:0] m_lfsr;
  logic        m_pend;
  logic [10:0] m_px, m_x;
  logic [9:0]  m_py, m_y;
  logic        m_pp, m_pop, m_upd;

  sprite_position_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .H_ACTIVE       (H_ACTIVE),
    .V_ACTIVE       (V_ACTIVE),
    .SPRITE_W       (SPRITE_W),
    .SPRITE_H       (SPRITE_H)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .btn_in      (btn_in),
    .new_frame_in(new_frame_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .pop_out     (pop_out),
    .update_out  (update_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbprev = 0; m_run = 0;
    m_lfsr = 16'hACE1;
    m_pend = 0; m_px = 0; m_py = 0; m_pp = 0;
    m_x = 0; m_y = 0; m_pop = 0; m_upd = 0;
  endtask

  // Advance the model across one clock edge with the given inputs
  task automatic model_step(input logic b, input logic nf);
    logic press_now;
    int   cx, cy;
    press_now = m_db && !m_dbprev;
    m_upd = nf && m_pend;
    if (m_upd) begin
      m_x = m_px; m_y = m_py; m_pop = m_pp;
    end
    if (press_now) begin
      cx     = int'(m_lfsr[10:0]);
      cy     = int'(m_lfsr[15:7]);
      m_px   = 11'(cx % (XMAX + 1));
      m_py   = 10'(cy % (YMAX + 1));
      m_pp   = m_lfsr[0];
      m_pend = 1;
    end else if (nf) begin
      m_pend = 0;
    end
    m_dbprev = m_db;
    // Accept a new level once it has disagreed for D consecutive cycles
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db  = !m_db;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2   = m_s1;
    m_s1   = b;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  task automatic checkOutput();
    check_val("x_out",      16'(x_out),       16'(m_x));
    check_val("y_out",      16'(y_out),       16'(m_y));
    check_val("pop_out",    16'(pop_out),     16'(m_pop));
    check_val("update_out", 16'(update_out),  16'(m_upd));
    check_val("pending",    16'(dut.pending), 16'(m_pend));
  endtask

  task automatic applyStimulus(input logic b, input logic nf);
    btn_in       = b;
    new_frame_in = nf;
    model_step(b, nf);
    @(posedge clk_in);
    #1;
    checkOutput();
  endtask

  // Hold the button until the model says a press is live, optionally deposit
  // an LFSR value for the capture edge, then release and let it settle.
  task automatic pressButton(input logic nf_on_capture, input logic do_dep, input logic [15:0] dep);
    int n;
    n = 0;
    while (!(m_db && !m_dbprev) && n < 20) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $error("[TB] FAIL press_timeout: observed no press after %0d cycles, required within 20", n);
    end
    if (do_dep) begin
      dut.lfsr_q = dep;
      m_lfsr     = dep;
    end
    applyStimulus(1'b1, nf_on_capture);
    repeat (8) applyStimulus(1'b0, 1'b0);
  endtask

  logic [10:0] cx_tab [3];
  logic [10:0] px_tab [3];
  logic [8:0]  cy_tab [3];
  logic [9:0]  py_tab [3];

  initial begin
    logic b;
    int   hold;
    logic nf;

    cx_tab = '{11'd1024, 11'd1025, 11'd2047};
    px_tab = '{11'd1024, 11'd0,    11'd1022};
    cy_tab = '{9'd464,   9'd465,   9'd511};
    py_tab = '{10'd464,  10'd0,    10'd46};

    btn_in = 0; new_frame_in = 0; rst_in = 1;
    model_reset();
    #1;
    check_val("reset_x",       16'(x_out),       16'd0);
    check_val("reset_y",       16'(y_out),       16'd0);
    check_val("reset_pop",     16'(pop_out),     16'd0);
    check_val("reset_update",  16'(update_out),  16'd0);
    check_val("reset_pending", 16'(dut.pending), 16'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    check_val("lfsr_seed", dut.lfsr_q, 16'hACE1);

    $display("[TB] frame pulses with no button activity");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, (i % 3) == 0);

    $display("[TB] press latency and commit");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0);
      check_val($sformatf("press_at_%0d", k), 16'(dut.press), 16'(k == 6));
    end
    repeat (12) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    check_val("commit_update_hi", 16'(update_out), 16'd1);
    applyStimulus(1'b1, 1'b0);
    check_val("commit_update_lo", 16'(update_out), 16'd0);
    repeat (10) applyStimulus(1'b0, 1'b0);

    $display("[TB] bounce rejection");
    for (int r = 0; r < 5; r++) begin
      repeat (3) applyStimulus(1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
    end
    check_val("bounce_pending", 16'(dut.pending), 16'd0);
    applyStimulus(1'b0, 1'b1);
    check_val("bounce_update", 16'(update_out), 16'd0);

    $display("[TB] position folding at range boundaries");
    for (int i = 0; i < 3; i++) begin
      pressButton(1'b0, 1'b1, {5'd0, cx_tab[i]});
      applyStimulus(1'b0, 1'b1);
      check_val($sformatf("fold_x_%0d", cx_tab[i]), 16'(x_out), 16'(px_tab[i]));
    end
    for (int i = 0; i < 3; i++) begin
      pressButton(1'b0, 1'b1, {cy_tab[i], 7'h01});
      applyStimulus(1'b0, 1'b1);
      check_val($sformatf("fold_y_%0d", cy_tab[i]), 16'(y_out), 16'(py_tab[i]));
    end

    $display("[TB] last press wins, press coincident with frame");
    pressButton(1'b0, 1'b0, 16'h0000);
    pressButton(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1);
    check_val("two_press_update", 16'(update_out), 16'd1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    pressButton(1'b0, 1'b0, 16'h0000);
    pressButton(1'b1, 1'b0, 16'h0000);
    check_val("coincident_pending", 16'(dut.pending), 16'd1);
    applyStimulus(1'b0, 1'b1);
    check_val("coincident_next_update", 16'(update_out), 16'd1);

    $display("[TB] asynchronous reset while armed");
    pressButton(1'b0, 1'b0, 16'h0000);
    #2;
    rst_in = 1;
    #1;
    check_val("async_rst_x",       16'(x_out),       16'd0);
    check_val("async_rst_y",       16'(y_out),       16'd0);
    check_val("async_rst_pop",     16'(pop_out),     16'd0);
    check_val("async_rst_update",  16'(update_out),  16'd0);
    check_val("async_rst_pending", 16'(dut.pending), 16'd0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    check_val("lfsr_seed_again", dut.lfsr_q, 16'hACE1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, (i % 2) == 0);

    $display("[TB] randomized traffic");
    b = 0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        b    = ~b;
        hold = int'($urandom_range(1, 10));
      end
      hold--;
      nf = ($urandom_range(0, 7) == 0);
      applyStimulus(b, nf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
